// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU load/store unit
// (port 0) and an auxiliary requester (port 1). Port 0 has default priority,
// port 1 is protected against starvation and may lock the memory for atomic
// sequences. Responses return to the issuing port MEM_LAT cycles after issue.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wen,
    input  logic [3:0]        req0_byte_en,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wen,
    input  logic [3:0]        req1_byte_en,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              mem_en,
    output logic              mem_wen,
    output logic [3:0]        mem_byte_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        OPEN,
        LOCKED
    } lock_state_t;

    lock_state_t        lock_state;
    logic [3:0]         starve;
    logic               lock_hold;
    logic               starved;
    logic               grant0;
    logic               grant1;

    logic [MEM_LAT-1:0] tag_valid;
    logic [MEM_LAT-1:0] tag_port;
    logic [MEM_LAT-1:0] tag_read;

    // Lock is only honoured while port 1 keeps req1_lock high; dropping it
    // reopens arbitration in the same cycle.
    assign lock_hold = (lock_state == LOCKED) && req1_lock;
    assign starved   = (starve == 4'(STARVE_MAX));

    // Arbitration: lock owner first, then starvation override, then port 0.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (lock_hold) begin
                grant1 = req1_valid;
            end else if (req1_valid && (starved || !req0_valid)) begin
                grant1 = 1'b1;
            end else begin
                grant0 = req0_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Memory-side mux of the winning request; idle outputs are all zero.
    always_comb begin
        mem_en      = 1'b0;
        mem_wen     = 1'b0;
        mem_byte_en = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (grant0) begin
            mem_en      = 1'b1;
            mem_wen     = req0_wen;
            mem_byte_en = req0_wen ? req0_byte_en : 4'b0000;
            mem_addr    = req0_addr;
            mem_wdata   = req0_wdata;
        end else if (grant1) begin
            mem_en      = 1'b1;
            mem_wen     = req1_wen;
            mem_byte_en = req1_wen ? req1_byte_en : 4'b0000;
            mem_addr    = req1_addr;
            mem_wdata   = req1_wdata;
        end
    end

    // Starvation counter: counts port-1 losses, saturates, clears on grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
        end else if (grant1) begin
            starve <= '0;
        end else if (req1_valid && !starved) begin
            starve <= starve + 4'd1;
        end
    end

    // Lock FSM: enter on a locked port-1 grant, leave when the lock drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state <= OPEN;
        end else begin
            case (lock_state)
                OPEN:    if (grant1 && req1_lock) lock_state <= LOCKED;
                LOCKED:  if (!req1_lock)          lock_state <= OPEN;
                default: lock_state <= OPEN;
            endcase
        end
    end

    // Tag pipeline: one entry per issued access, emerging after MEM_LAT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_port  <= '0;
            tag_read  <= '0;
        end else begin
            tag_valid[0] <= mem_en;
            tag_port[0]  <= grant1;
            tag_read[0]  <= mem_en && !mem_wen;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_port[i]  <= tag_port[i-1];
                tag_read[i]  <= tag_read[i-1];
            end
        end
    end

    // Response steering: read data is taken straight from the memory as it
    // arrives, so it is combinational on the registered tag.
    always_comb begin
        rsp0_valid = tag_valid[MEM_LAT-1] && !tag_port[MEM_LAT-1];
        rsp1_valid = tag_valid[MEM_LAT-1] &&  tag_port[MEM_LAT-1];
        rsp0_rdata = (rsp0_valid && tag_read[MEM_LAT-1]) ? mem_rdata : '0;
        rsp1_rdata = (rsp1_valid && tag_read[MEM_LAT-1]) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: two instances (MEM_LAT 1 and 3) share one
// stimulus stream; each has its own behavioural memory, and a transaction
// level reference model predicts grants, memory outputs and responses.
module tb_dmem_arbiter;

    localparam int SM = 4;

    logic        clk;
    logic        rst;
    logic        v0, w0, v1, w1, lk;
    logic [3:0]  be0, be1;
    logic [31:0] a0, d0, a1, d1;

    logic        rdy0_a, rdy1_a, rv0_a, rv1_a, en_a, wen_a;
    logic [3:0]  mbe_a;
    logic [31:0] rd0_a, rd1_a, maddr_a, mwd_a, mrd_a;
    logic        rdy0_b, rdy1_b, rv0_b, rv1_b, en_b, wen_b;
    logic [3:0]  mbe_b;
    logic [31:0] rd0_b, rd1_b, maddr_b, mwd_b, mrd_b;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SM)) u_a (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(rdy0_a), .req0_wen(w0), .req0_byte_en(be0),
        .req0_addr(a0), .req0_wdata(d0), .rsp0_valid(rv0_a), .rsp0_rdata(rd0_a),
        .req1_valid(v1), .req1_ready(rdy1_a), .req1_wen(w1), .req1_byte_en(be1),
        .req1_addr(a1), .req1_wdata(d1), .req1_lock(lk),
        .rsp1_valid(rv1_a), .rsp1_rdata(rd1_a),
        .mem_en(en_a), .mem_wen(wen_a), .mem_byte_en(mbe_a), .mem_addr(maddr_a),
        .mem_wdata(mwd_a), .mem_rdata(mrd_a)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SM)) u_b (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(rdy0_b), .req0_wen(w0), .req0_byte_en(be0),
        .req0_addr(a0), .req0_wdata(d0), .rsp0_valid(rv0_b), .rsp0_rdata(rd0_b),
        .req1_valid(v1), .req1_ready(rdy1_b), .req1_wen(w1), .req1_byte_en(be1),
        .req1_addr(a1), .req1_wdata(d1), .req1_lock(lk),
        .rsp1_valid(rv1_b), .rsp1_rdata(rd1_b),
        .mem_en(en_b), .mem_wen(wen_b), .mem_byte_en(mbe_b), .mem_addr(maddr_b),
        .mem_wdata(mwd_b), .mem_rdata(mrd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memories; non-read cycles return junk so write responses
    // must be zeroed by the arbiter itself.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];
    assign mrd_a = pipe_a;
    assign mrd_b = pipe_b[2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= '0;
        end else if (en_a && wen_a) begin
            for (int k = 0; k < 4; k++)
                if (mbe_a[k]) mem_a[maddr_a[9:2]][8*k +: 8] <= mwd_a[8*k +: 8];
        end
        pipe_a <= (en_a && !wen_a) ? mem_a[maddr_a[9:2]] : 32'hA5A5_5A5A;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= '0;
        end else if (en_b && wen_b) begin
            for (int k = 0; k < 4; k++)
                if (mbe_b[k]) mem_b[maddr_b[9:2]][8*k +: 8] <= mwd_b[8*k +: 8];
        end
        pipe_b[0] <= (en_b && !wen_b) ? mem_b[maddr_b[9:2]] : 32'h5A5A_A5A5;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    // Reference model state: transaction history indexed by cycle number.
    int          cyc = 0;
    int          starve_m = 0;
    bit          locked_m = 0;
    bit          g0_m, g1_m;
    logic [31:0] mm [256];
    bit          hv [8];
    bit          hp [8];
    bit          hr [8];
    logic [31:0] hd [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r,
                        input bit v0_, input bit w0_, input logic [3:0] be0_,
                        input logic [31:0] a0_, input logic [31:0] d0_,
                        input bit v1_, input bit w1_, input logic [3:0] be1_,
                        input logic [31:0] a1_, input logic [31:0] d1_,
                        input bit lk_);
        bit          ew;
        logic [3:0]  ebe;
        logic [31:0] ea, ed;
        bit          erv0, erv1;
        logic [31:0] erd0, erd1;
        int          idx;
        @(negedge clk);
        rst = r; v0 = v0_; w0 = w0_; be0 = be0_; a0 = a0_; d0 = d0_;
        v1 = v1_; w1 = w1_; be1 = be1_; a1 = a1_; d1 = d1_; lk = lk_;
        #1;
        g0_m = 0;
        g1_m = 0;
        if (r) begin
            for (int i = 0; i < 8; i++) hv[i] = 0;
            for (int i = 0; i < 256; i++) mm[i] = '0;
            starve_m = 0;
            locked_m = 0;
        end else if (locked_m && lk_) begin
            g1_m = v1_;                  // lock owner only
        end else if (v1_ && (!v0_ || starve_m == SM)) begin
            g1_m = 1;                    // alone, or starvation override
        end else begin
            g0_m = v0_;                  // default priority
        end

        ew  = g0_m ? w0_ : (g1_m ? w1_ : 1'b0);
        ebe = ew ? (g0_m ? be0_ : be1_) : 4'b0000;
        ea  = g0_m ? a0_ : (g1_m ? a1_ : 32'd0);
        ed  = g0_m ? d0_ : (g1_m ? d1_ : 32'd0);

        check("ctl_L1", 64'({rdy0_a, rdy1_a, en_a, wen_a, mbe_a}),
              64'({g0_m, g1_m, g0_m | g1_m, ew, ebe}));
        check("addr_L1", 64'(maddr_a), 64'(ea));
        check("wdata_L1", 64'(mwd_a), 64'(ed));
        check("ctl_L3", 64'({rdy0_b, rdy1_b, en_b, wen_b, mbe_b}),
              64'({g0_m, g1_m, g0_m | g1_m, ew, ebe}));
        check("addr_L3", 64'(maddr_b), 64'(ea));
        check("wdata_L3", 64'(mwd_b), 64'(ed));

        for (int l = 1; l <= 3; l += 2) begin
            idx  = (cyc - l) & 7;
            erv0 = (cyc >= l) && hv[idx] && !hp[idx];
            erv1 = (cyc >= l) && hv[idx] &&  hp[idx];
            erd0 = (erv0 && hr[idx]) ? hd[idx] : 32'd0;
            erd1 = (erv1 && hr[idx]) ? hd[idx] : 32'd0;
            if (l == 1) begin
                check("rsp_L1", 64'({rv0_a, rv1_a}), 64'({erv0, erv1}));
                check("rdata_L1", {rd0_a, rd1_a}, {erd0, erd1});
            end else begin
                check("rsp_L3", 64'({rv0_b, rv1_b}), 64'({erv0, erv1}));
                check("rdata_L3", {rd0_b, rd1_b}, {erd0, erd1});
            end
        end

        idx     = cyc & 7;
        hv[idx] = g0_m | g1_m;
        hp[idx] = g1_m;
        hr[idx] = (g0_m | g1_m) && !ew;
        hd[idx] = mm[ea[9:2]];

        if (!r) begin
            if (g1_m) starve_m = 0;
            else if (v1_ && starve_m < SM) starve_m++;
            locked_m = locked_m ? lk_ : (g1_m && lk_);
            if ((g0_m | g1_m) && ew)
                for (int k = 0; k < 4; k++)
                    if (ebe[k]) mm[ea[9:2]][8*k +: 8] = ed[8*k +: 8];
        end
        cyc++;
    endtask

    task automatic idle(input bit r);
        step(r, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    endtask

    initial begin
        rst = 1'b1; v0 = 0; w0 = 0; be0 = '0; a0 = '0; d0 = '0;
        v1 = 0; w1 = 0; be1 = '0; a1 = '0; d1 = '0; lk = 0;

        // Reset held with both ports requesting
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0, 0);
            check("rst_quiet", 64'({rdy0_a, rdy1_a, en_a, rv0_a, rv1_a}), 64'd0);
        end

        // Continuous contention: port 1 wins every fifth cycle
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 4'hF, 32'(8 * i), 32'h0, 1, 0, 4'hF, 32'(8 * i + 4), 32'h0, 0);
            check("contend_p0", 64'(rdy0_a), 64'(!(i == 4 || i == 9)));
            check("contend_p1", 64'(rdy1_a), 64'(i == 4 || i == 9));
        end
        idle(0);
        idle(0);
        idle(0);

        // Port-0 write then read of 0x40
        step(0, 1, 1, 4'hF, 32'h40, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        step(0, 1, 0, 4'hF, 32'h40, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        check("rd_byte_en", 64'(mbe_a), 64'd0);
        idle(0);
        check("rd_deadbeef", 64'({rv0_a, rd0_a}), {31'd0, 1'b1, 32'hDEADBEEF});
        idle(0);
        idle(0);

        // Lock sequence with port 0 requesting throughout
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 4'h0, 32'h200, 32'h0, 1, 1, 4'b0011, 32'h100, 32'h12345678, 1);
            if (g1_m) break;
        end
        step(0, 1, 0, 4'h0, 32'h200, 32'h0, 1, 0, 4'h0, 32'h100, 32'h0, 1);
        check("lock_rd", 64'({rdy0_a, rdy1_a}), 64'b01);
        step(0, 1, 0, 4'h0, 32'h200, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
        check("lock_block", 64'(rdy0_a), 64'd0);
        check("lock_rdata", 64'({rv1_a, rd1_a}), {31'd0, 1'b1, 32'h00005678});
        step(0, 1, 0, 4'h0, 32'h200, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        check("unlock_p0", 64'(rdy0_a), 64'd1);
        idle(0);
        idle(0);
        idle(0);

        // Pipelined reads 0/1/0
        step(0, 1, 0, 4'h0, 32'h40, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h0, 32'h100, 32'h0, 0);
        step(0, 1, 0, 4'h0, 32'h04, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        idle(0);
        check("pipe_r0", 64'({rv0_b, rv1_b, rd0_b}), {30'd0, 2'b10, 32'hDEADBEEF});
        idle(0);
        check("pipe_r1", 64'({rv0_b, rv1_b, rd1_b}), {30'd0, 2'b01, 32'h00005678});
        idle(0);
        check("pipe_r2", 64'({rv0_b, rv1_b, rd0_b}), {30'd0, 2'b10, 32'h0});
        idle(0);

        // Reset with reads in flight
        step(0, 1, 0, 4'h0, 32'h40, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h0, 32'h100, 32'h0, 0);
        idle(1);
        for (int i = 0; i < 4; i++) begin
            idle(0);
            check("flush_L3", 64'({rv0_b, rv1_b}), 64'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit r_, lkr;
            r_  = ($urandom_range(0, 149) == 0);
            lkr = ($urandom_range(0, 5) == 0) ? !lk : lk;
            step(r_,
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 4'($urandom),
                 {22'd0, 8'($urandom), 2'b00}, $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom),
                 {22'd0, 8'($urandom), 2'b00}, $urandom,
                 lkr);
        end
        for (int i = 0; i < 4; i++) idle(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
